// File: rtl/servant_gpio_bank.sv
// servant_gpio_bank: WIDTH-pin GPIO peripheral on a Wishbone slave slot.
// Per-pin direction, synchronised inputs, rise/fall edge detection with
// sticky pending bits and a single level interrupt (OR of pending bits).
//
// Handshake: a request is i_wb_cyc sampled high while o_wb_ack is low.
// Every request is acknowledged with a one-cycle o_wb_ack on the next edge.
// Write side effects and the registered read data land on that same edge.
// The master must drop i_wb_cyc after ack, so each access takes 2 clocks.
module servant_gpio_bank #(
  parameter int               WIDTH          = 8,
  parameter int               SYNC_STAGES    = 2,
  parameter logic [WIDTH-1:0] OUT_RESET      = '0,
  parameter                   RESET_STRATEGY = "MINI"
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic [3:0]       i_wb_sel,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack,
  input  logic [WIDTH-1:0] i_gpio,
  output logic [WIDTH-1:0] o_gpio,
  output logic [WIDTH-1:0] o_gpio_oe,
  output logic             o_irq
);

  // "NONE" keeps only the state that must be clean after reset; all other
  // registers come up with whatever they held before.
  localparam bit         LP_FULL_RST = (RESET_STRATEGY == "MINI");
  // Warm-up covers the synchroniser plus the prev stage, so a pin held high
  // through reset cannot appear as a rising edge.
  localparam logic [2:0] LP_WARM_MAX = 3'(SYNC_STAGES + 1);

  localparam logic [2:0] A_OUT  = 3'd0;
  localparam logic [2:0] A_DIR  = 3'd1;
  localparam logic [2:0] A_IN   = 3'd2;
  localparam logic [2:0] A_RISE = 3'd3;
  localparam logic [2:0] A_FALL = 3'd4;
  localparam logic [2:0] A_PEND = 3'd5;
  localparam logic [2:0] A_TGL  = 3'd6;

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [2:0]       r_warm;
  logic             r_ack;
  logic [31:0]      r_rdt;

  logic             w_req;
  logic             w_wr;
  logic [31:0]      w_mask32;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_dat;
  logic [WIDTH-1:0] w_in;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic             w_warm_done;
  logic [WIDTH-1:0] w_pend_set;
  logic [WIDTH-1:0] w_pend_clr;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_req    = i_wb_cyc & ~r_ack;
  assign w_wr     = w_req & i_wb_we;
  assign w_mask32 = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}},
                     {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
  assign w_mask   = w_mask32[WIDTH-1:0];
  assign w_dat    = i_wb_dat[WIDTH-1:0];
  // Data/lane bits above WIDTH have no register behind them.
  assign w_unused = ^{i_wb_dat, w_mask32};

  assign w_in        = r_sync[SYNC_STAGES-1];
  assign w_rise      = w_in & ~r_prev;
  assign w_fall      = ~w_in & r_prev;
  assign w_warm_done = (r_warm == LP_WARM_MAX);
  assign w_pend_set  = w_warm_done ? ((w_rise & r_rise_en) | (w_fall & r_fall_en))
                                   : '0;
  assign w_pend_clr  = (w_wr && i_wb_adr == A_PEND) ? (w_dat & w_mask) : '0;

  // Read mux: unimplemented bits, TOGGLE and reserved read as zero.
  always_comb begin
    w_rdata = '0;
    case (i_wb_adr)
      A_OUT:   w_rdata[WIDTH-1:0] = r_out;
      A_DIR:   w_rdata[WIDTH-1:0] = r_dir;
      A_IN:    w_rdata[WIDTH-1:0] = w_in;
      A_RISE:  w_rdata[WIDTH-1:0] = r_rise_en;
      A_FALL:  w_rdata[WIDTH-1:0] = r_fall_en;
      A_PEND:  w_rdata[WIDTH-1:0] = r_pend;
      default: w_rdata = '0;
    endcase
  end

  // Input synchroniser chain and previous-value stage for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      if (LP_FULL_RST) begin
        for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        r_prev <= '0;
      end
    end else begin
      r_sync[0] <= i_gpio;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_prev <= w_in;
    end
  end

  // Warm-up counter: saturates once the synchroniser holds real pin data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_warm <= '0;
    end else if (!w_warm_done) begin
      r_warm <= r_warm + 3'd1;
    end
  end

  // Sticky pending bits: a new enabled edge wins over a same-cycle W1C.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;
    end
  end

  // Bus handshake and registered read data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack <= 1'b0;
      if (LP_FULL_RST) r_rdt <= '0;
    end else begin
      r_ack <= w_req;
      if (w_req) r_rdt <= w_rdata;
    end
  end

  // Byte-masked writes to the control registers; TOGGLE flips OUT bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      if (LP_FULL_RST) begin
        r_out     <= OUT_RESET;
        r_dir     <= '0;
        r_rise_en <= '0;
        r_fall_en <= '0;
      end
    end else if (w_wr) begin
      case (i_wb_adr)
        A_OUT:   r_out     <= (r_out & ~w_mask) | (w_dat & w_mask);
        A_DIR:   r_dir     <= (r_dir & ~w_mask) | (w_dat & w_mask);
        A_RISE:  r_rise_en <= (r_rise_en & ~w_mask) | (w_dat & w_mask);
        A_FALL:  r_fall_en <= (r_fall_en & ~w_mask) | (w_dat & w_mask);
        A_TGL:   r_out     <= r_out ^ (w_dat & w_mask);
        default: ;
      endcase
    end
  end

  assign o_wb_ack  = r_ack;
  assign o_wb_rdt  = r_rdt;
  assign o_gpio    = r_out;
  assign o_gpio_oe = r_dir;
  assign o_irq     = |r_pend;

endmodule

// File: tb/tb_servant_gpio_bank.sv
// Bench for servant_gpio_bank: an 8-bit instance (OUT_RESET=0x3C) and a
// 32-bit instance share one Wishbone bus. Read expectations are queued when
// an access is issued and compared when the ack comes back.
module tb_servant_gpio_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_we  = 1'b0;
  logic        wb_cyc = 1'b0;

  logic [31:0] rdt8, rdt32;
  logic        ack8, ack32;
  logic [7:0]  gpio8 = '0;
  logic [7:0]  out8, oe8;
  logic        irq8;
  logic [31:0] gpio32 = '0;
  logic [31:0] out32, oe32;
  logic        irq32;

  int n_checks = 0;
  int n_fail   = 0;

  // Entry: {use_32bit_instance, is_read, expected_rdt}
  logic [33:0] exp_q[$];

  servant_gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .OUT_RESET(8'h3C)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat),
    .i_wb_sel(wb_sel), .i_wb_we(wb_we), .i_wb_cyc(wb_cyc),
    .o_wb_rdt(rdt8), .o_wb_ack(ack8), .i_gpio(gpio8), .o_gpio(out8),
    .o_gpio_oe(oe8), .o_irq(irq8)
  );

  servant_gpio_bank #(.WIDTH(32), .SYNC_STAGES(2), .OUT_RESET(32'h0)) u_dut32 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat),
    .i_wb_sel(wb_sel), .i_wb_we(wb_we), .i_wb_cyc(wb_cyc),
    .o_wb_rdt(rdt32), .o_wb_ack(ack32), .i_gpio(gpio32), .o_gpio(out32),
    .o_gpio_oe(oe32), .o_irq(irq32)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Scoreboard: pop one entry per ack, compare read data when it is a read.
  always @(negedge clk) begin
    if (ack8) begin
      if (exp_q.size() == 0) begin
        check("ack_without_txn", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        if (e[32]) begin
          if (e[33]) check("rd32", rdt32, e[31:0]);
          else       check("rd8", rdt8, e[31:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One Wishbone access; checks ack latency and single-cycle ack width.
  task automatic bus(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input logic we, input logic is_rd, input logic use32,
                     input logic [31:0] exp);
    int lat;
    @(negedge clk);
    exp_q.push_back({use32, is_rd, exp});
    wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we; wb_cyc = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack8 && lat < 4);
    check("ack_latency", 32'(lat), 32'd1);
    @(negedge clk);
    wb_cyc = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", {31'd0, ack8}, 32'd0);
  endtask

  task automatic wr(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus(adr, dat, sel, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic rd8(input logic [2:0] adr, input logic [31:0] exp);
    bus(adr, 32'd0, 4'h0, 1'b0, 1'b1, 1'b0, exp);
  endtask

  task automatic rd32(input logic [2:0] adr, input logic [31:0] exp);
    bus(adr, 32'd0, 4'h0, 1'b0, 1'b1, 1'b1, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] reset_vals [8];

  initial begin
    reset_vals = '{32'h3C, 0, 0, 0, 0, 0, 0, 0};
    tick(3);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ack", {31'd0, ack8}, 32'd0);
    check("rst_out", {24'd0, out8}, 32'h3C);
    check("rst_oe", {24'd0, oe8}, 32'h0);
    check("rst_irq", {31'd0, irq8}, 32'd0);
    for (int a = 0; a < 8; a++) rd8(3'(a), reset_vals[a]);

    // OUT/DIR/TOGGLE with byte lanes
    wr(3'd0, 32'h0000_00A5, 4'b0001);
    check("out_a5", {24'd0, out8}, 32'hA5);
    wr(3'd1, 32'h0000_00FF, 4'b1111);
    check("oe_ff", {24'd0, oe8}, 32'hFF);
    wr(3'd6, 32'h0000_000F, 4'b0001);
    check("toggle", {24'd0, out8}, 32'hAA);
    wr(3'd0, 32'h0000_0055, 4'b0000);
    check("out_sel0", {24'd0, out8}, 32'hAA);
    wr(3'd0, 32'hFFFF_FF11, 4'b1110);
    wr(3'd6, 32'h0000_00FF, 4'b0000);
    rd8(3'd0, 32'h0000_00AA);
    rd8(3'd6, 32'h0);

    // Rising edge on bit 0, latency to o_irq
    wr(3'd3, 32'h01, 4'b0001);
    @(negedge clk);
    gpio8[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("irq_before", {31'd0, irq8}, 32'd0);
    @(posedge clk); #1;
    check("irq_after", {31'd0, irq8}, 32'd1);
    rd8(3'd2, 32'h01);
    rd8(3'd5, 32'h01);
    wr(3'd5, 32'h01, 4'b0001);
    @(negedge clk);
    gpio8[0] = 1'b0;
    tick(4);
    rd8(3'd5, 32'h00);
    check("irq_fall_ignored", {31'd0, irq8}, 32'd0);

    // Two pending bits, partial W1C, set-wins against W1C
    wr(3'd3, 32'h03, 4'b0001);
    @(negedge clk);
    gpio8 = 8'h03;
    tick(4);
    rd8(3'd5, 32'h03);
    wr(3'd5, 32'h01, 4'b0001);
    rd8(3'd5, 32'h02);
    @(negedge clk);
    gpio8[1] = 1'b0;
    tick(4);
    rd8(3'd5, 32'h02);
    @(negedge clk);
    gpio8[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    wr(3'd5, 32'h02, 4'b0001);
    rd8(3'd5, 32'h02);
    wr(3'd5, 32'hFF, 4'b0000);
    rd8(3'd5, 32'h02);
    wr(3'd5, 32'h02, 4'b0001);
    rd8(3'd5, 32'h00);

    // Bits above WIDTH read back as zero
    wr(3'd0, 32'hFFFF_FFFF, 4'b1111);
    rd8(3'd0, 32'h0000_00FF);

    // Pins held high through reset: no spurious rise
    @(negedge clk);
    rst = 1'b1;
    gpio8 = 8'hFF;
    tick(2);
    @(negedge clk);
    rst = 1'b0;
    wr(3'd3, 32'hFF, 4'b0001);
    tick(4);
    rd8(3'd5, 32'h00);
    check("warm_irq", {31'd0, irq8}, 32'd0);
    @(negedge clk);
    gpio8[3] = 1'b0;
    tick(4);
    @(negedge clk);
    gpio8[3] = 1'b1;
    tick(4);
    rd8(3'd5, 32'h08);

    // 32-bit instance: reserved and IN writes are ignored
    @(negedge clk);
    gpio32 = 32'h1234_5678;
    do_reset();
    wr(3'd7, 32'hFFFF_FFFF, 4'b1111);
    wr(3'd2, 32'hFFFF_FFFF, 4'b1111);
    for (int a = 0; a < 8; a++)
      rd32(3'(a), (a == 2) ? 32'h1234_5678 : 32'h0);
    check("w32_out", out32, 32'h0);
    check("w32_irq", {31'd0, irq32}, 32'd0);

    // Reset asserted while a write is on the bus: no ack, no commit
    @(negedge clk);
    rst = 1'b1;
    wb_adr = 3'd0; wb_dat = 32'hFFFF_FFFF; wb_sel = 4'hF; wb_we = 1'b1; wb_cyc = 1'b1;
    @(posedge clk); #1;
    check("midrst_ack", {31'd0, ack8}, 32'd0);
    check("midrst_out8", {24'd0, out8}, 32'h3C);
    check("midrst_out32", out32, 32'h0);
    @(negedge clk);
    wb_cyc = 1'b0; wb_we = 1'b0;
    rst = 1'b0;
    tick(2);
    check("midrst_ack_after", {31'd0, ack8}, 32'd0);
    rd8(3'd0, 32'h3C);

    tick(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
